// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Brief    : 4-digit common-anode display scanner with frame-aligned
//            double buffering, dead time and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
  parameter int CLK_DIV = 100000,
  parameter int DEAD    = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  hex_out,
  output logic [3:0]  disp_select,
  output logic        dp_out,
  output logic        frame_done
);

  localparam int                c_PC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_PC_W-1:0] c_PC_LAST = c_PC_W'(CLK_DIV - 1);

  logic [c_PC_W-1:0] r_pc;
  logic [1:0]        r_digit;
  logic [15:0]       r_pending;
  logic [15:0]       r_active;

  logic              w_slotEnd;
  logic              w_frameEnd;
  logic [3:0]        w_nibble;
  logic              w_live;
  logic              w_upperZero;
  logic              w_lit;
  logic [3:0]        w_sel;

  assign w_slotEnd  = (r_pc == c_PC_LAST);
  assign w_frameEnd = w_slotEnd && (r_digit == 2'd3);
  assign w_nibble   = r_active[{r_digit, 2'b00} +: 4];

  // The slot is dark during its first DEAD cycles; DEAD=0 removes the compare.
  generate
    if (DEAD == 0) begin : g_noDead
      assign w_live = 1'b1;
    end else begin : g_dead
      localparam logic [c_PC_W-1:0] c_DEAD = c_PC_W'(DEAD);
      assign w_live = (r_pc >= c_DEAD);
    end
  endgenerate

  // Digit k is a leading zero when every nibble from k upward is zero.
  always_comb begin
    w_upperZero = 1'b0;
    case (r_digit)
      2'd0:    w_upperZero = 1'b0;
      2'd1:    w_upperZero = (r_active[15:4]  == 12'h000);
      2'd2:    w_upperZero = (r_active[15:8]  == 8'h00);
      default: w_upperZero = (r_active[15:12] == 4'h0);
    endcase
  end

  assign w_lit = w_live && digit_en[r_digit] && !(blank_lz && w_upperZero);
  assign w_sel = w_lit ? ~(4'b0001 << r_digit) : 4'b1111;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= '0;
      r_digit     <= 2'd0;
      r_pending   <= 16'h0000;
      r_active    <= 16'h0000;
      hex_out     <= 4'h0;
      disp_select <= 4'b1111;
      dp_out      <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      r_pc <= w_slotEnd ? '0 : r_pc + 1'b1;
      if (w_slotEnd) begin
        r_digit <= r_digit + 2'd1;
      end
      if (load) begin
        r_pending <= value;
      end
      // A load on the boundary edge bypasses the pending buffer.
      if (w_frameEnd) begin
        r_active <= load ? value : r_pending;
      end
      hex_out     <= w_nibble;
      disp_select <= w_sel;
      dp_out      <= ~(dp_in[r_digit] & w_lit);
      frame_done  <= w_frameEnd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan
// Brief    : Self-checking bench for seven_seg_scan: directed frames plus a
//            randomized run against a cycle-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  localparam int CLK_DIV = 4;
  localparam int DEAD    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [3:0]  hex_out;
  logic [3:0]  disp_select;
  logic        dp_out;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  seven_seg_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .digit_en(digit_en), .dp_in(dp_in), .hex_out(hex_out),
    .disp_select(disp_select), .dp_out(dp_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan follows from cycles since reset.
  int          mT, mPc, mD;
  logic [15:0] mPend, mAct;
  logic [3:0]  eHex, eSel;
  logic        eDp, eFd, mLit, mBlank;

  initial begin
    #2;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mT = 0; mPend = 16'h0; mAct = 16'h0;
        eHex = 4'h0; eSel = 4'hF; eDp = 1'b1; eFd = 1'b0;
      end else begin
        mPc    = mT % CLK_DIV;
        mD     = (mT / CLK_DIV) % 4;
        mBlank = blank_lz && (mD > 0) && ((mAct >> (4 * mD)) == 16'h0);
        mLit   = (mPc >= DEAD) && digit_en[mD] && !mBlank;
        eHex   = 4'((mAct >> (4 * mD)) & 16'hF);
        eSel   = 4'hF;
        if (mLit) eSel[mD] = 1'b0;
        eDp    = !(dp_in[mD] && mLit);
        eFd    = (mPc == CLK_DIV - 1) && (mD == 3);
        if (eFd) mAct = load ? value : mPend;
        if (load) mPend = value;
        mT++;
      end
      #1;
      check("model_hex", hex_out, eHex);
      check("model_sel", disp_select, eSel);
      check("model_dp", dp_out, eDp);
      check("model_frame_done", frame_done, eFd);
    end
  end

  task automatic waitFrame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * CLK_DIV + 4; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL frame_wait actual=timeout required=frame_done pulse");
    end
  endtask

  // Checks one whole frame starting right after a frame_done sample (DEAD=1:
  // pc 0 of every slot is dark). Optionally drives new inputs after step loadAt.
  task automatic checkFrame(input logic [15:0] v, input logic [3:0] litMask,
                            input int loadAt, input logic [15:0] newV,
                            input logic newBlank, input logic [3:0] newEn,
                            input logic [3:0] newDp);
    int slot, pc;
    logic [3:0] expSel;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      slot   = j / 4;
      pc     = j % 4;
      expSel = 4'hF;
      if (pc != 0 && litMask[slot]) expSel[slot] = 1'b0;
      check("frame_sel", disp_select, expSel);
      check("frame_hex", hex_out, v[4*slot +: 4]);
      check("frame_dp", dp_out, 1'b1);
      check("frame_done", frame_done, j == 15);
      if (j == loadAt) begin
        #1;
        value = newV; load = 1'b1; blank_lz = newBlank;
        digit_en = newEn; dp_in = newDp;
      end else if (load) begin
        #1;
        load = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; value = 16'h0; load = 1'b0; blank_lz = 1'b0;
    digit_en = 4'hF; dp_in = 4'h0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_hex", hex_out, 4'h0);
    check("rst_sel", disp_select, 4'hF);
    check("rst_dp", dp_out, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);

    reset = 1'b0; value = 16'h1234; load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    waitFrame();

    checkFrame(16'h1234, 4'hF, 5,  16'hABCD, 1'b0, 4'hF, 4'h0);
    checkFrame(16'hABCD, 4'hF, 14, 16'h00F0, 1'b0, 4'hF, 4'h0);
    checkFrame(16'h00F0, 4'hF, 15, 16'h0050, 1'b1, 4'hF, 4'h0);
    checkFrame(16'h00F0, 4'b0011, -1, 16'h0, 1'b0, 4'h0, 4'h0);
    checkFrame(16'h0050, 4'b0011, 8,  16'h0000, 1'b1, 4'hF, 4'h0);
    checkFrame(16'h0000, 4'b0001, 15, 16'h1234, 1'b0, 4'b1011, 4'b0100);
    checkFrame(16'h0000, 4'b1011, -1, 16'h0, 1'b0, 4'h0, 4'h0);
    checkFrame(16'h1234, 4'b1011, -1, 16'h0, 1'b0, 4'h0, 4'h0);

    // Asynchronous reset with the scan at digit 2, pc 2.
    repeat (10) @(posedge clk);
    #4;
    reset = 1'b1;
    #2;
    check("async_rst_hex", hex_out, 4'h0);
    check("async_rst_sel", disp_select, 4'hF);
    check("async_rst_dp", dp_out, 1'b1);
    check("async_rst_frame_done", frame_done, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    checkFrame(16'h0000, 4'b1011, -1, 16'h0, 1'b0, 4'h0, 4'h0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      value    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      blank_lz = 1'($urandom);
      digit_en = 4'($urandom);
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
      end
    end

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
